bus_gather: RTL and testbench
=============================

Name: bus_gather

Overview:
- Parametrised width upsizer for vector buses.
- Accepts IN_W-bit beats over a valid/ready handshake and packs RATIO beats LSB-lane-first into one IN_W*RATIO-bit word.
- Supports early termination: partial words are padded with a constant fill.
- Successor to the fixed-width hand-written slice/concatenation glue: the lane mapping, padding and flow control become parametrised and registered.

Parameters:
- IN_W, 8, width of one input beat (lane); ≥1.
- RATIO, 4, beats per output word; ≥2.
- PAD_BIT, 1'b0, value replicated into lanes not filled before in_last.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  IN_W  beat payload.
- in_last  input  1  beat closes the current word, even if partial.
- out_valid  output  1  packed word held.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  IN_W*RATIO  packed word; lane k = bits [k*IN_W +: IN_W].
- out_count  output  CNT_W  number of filled lanes, 1..RATIO; CNT_W = $clog2(RATIO+1).

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_data=0, out_count=0.
  - Lane counter cnt=0; accumulator cleared.
  - in_ready reads 1 in the cycle after reset.
- Mid-operation reset discards any partial accumulation and any held word, with no output pulse.
- Accept condition: in_valid && in_ready.
- Flow control: in_ready = !out_valid || out_ready.
  - Purely combinational.
  - No combinational path from in_valid or in_last to in_ready.
- State machine, cnt in 0..RATIO-1:
  - FILL: accepted beat with cnt<RATIO-1 and !in_last → data written to lane cnt of the accumulator; cnt++.
  - CLOSE: accepted beat with cnt==RATIO-1, or with in_last=1.
    - Next cycle: out_data = accumulator lanes 0..cnt-1, in_data in lane cnt, lanes above cnt filled with {IN_W{PAD_BIT}}.
    - out_count = cnt+1; out_valid=1; cnt=0.
- Latency: out_valid rises 1 cycle after the closing beat is accepted.
- Throughput: one beat per cycle sustained while out_ready=1, i.e. one word every RATIO cycles at full rate.
- Output hold: while out_valid && !out_ready, out_data and out_count stay stable and in_ready=0.
- Output drain: out_valid && out_ready && no closing beat this cycle → out_valid=0 next cycle.
- Simultaneous drain and close in the same cycle: the new word replaces the old word; out_valid stays 1 with no bubble.
- in_last on lane 0: a single-lane word, out_count=1, lanes 1..RATIO-1 padded.
- in_last on lane RATIO-1: identical to a normal full word.
- cnt wraps RATIO-1→0 only on CLOSE, never by overflow.
- Beats presented while in_ready=0 are neither consumed nor visible in state.
- in_data, in_last are don't-care when in_valid=0.

Optional Feature:
- Macro: BUS_GATHER_PARITY_EN.
- Defined:
  - Adds output port out_parity, RATIO bits wide.
  - Bit k = even parity (XOR reduction) of lane k of out_data, padded lanes included.
  - Registered together with out_data; reset 0; same timing and hold rules as out_data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bus_gather_pkg:
  - Function count_width(ratio) returning $clog2(ratio+1).
  - Function lane_parity(vector, lane width) used under the macro.
  - Default-parameter localparams.
- No sub-module; accumulator, counter and output register sit in one module.
- Lane write implemented as an indexed part-select inside a generate loop over RATIO.

Test Plan:
- Full word (IN_W=8, RATIO=4, out_ready=1): beats 0x11,0x22,0x33,0x44, last on 4th → one cycle later out_data=0x44332211, out_count=4, out_valid for exactly 1 cycle.
- Partial word, PAD_BIT=0: beats 0xAA, 0xBB with last on 2nd → out_data=0x0000BBAA, out_count=2. Repeat with PAD_BIT=1 → 0xFFFFBBAA.
- Back-pressure: hold out_ready=0 after word 0x44332211 → in_ready=0 and out_data stable for 10 cycles. Raise out_ready while the next closing beat is presented → next word appears with out_valid continuously high.
- Back-to-back: 12 continuous beats 0x01..0x0C, out_ready=1 → words 0x04030201, 0x08070605, 0x0C0B0A09, each 1 cycle after its 4th beat, no dropped beats.
- Reset mid-fill: after beats 0x11,0x22 assert rst 1 cycle, then send 0x55 with last → out_data=0x00000055, out_count=1 (no 0x11/0x22 residue).
- Parity (BUS_GATHER_PARITY_EN): word 0x01030700 → out_parity=4'b1010; macro undefined → build has no out_parity port.

Source files
------------

// File: rtl/bus_gather_pkg.sv
// Shared helpers and default sizing for the bus_gather width upsizer.
// lane_parity is only called when BUS_GATHER_PARITY_EN is defined.
package bus_gather_pkg;

   localparam int   DEF_IN_W    = 8;
   localparam int   DEF_RATIO   = 4;
   localparam logic DEF_PAD_BIT = 1'b0;
   localparam int   LANE_MAX_W  = 1024;

   function automatic int count_width(input int ratio);
      return $clog2(ratio + 1);
   endfunction

   // Even parity over the low 'width' bits of a zero-extended lane.
   function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane, input int width);
      logic p;
      p = 1'b0;
      for (int i = 0; i < LANE_MAX_W; i++) begin
         if (i < width) p = p ^ lane[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/bus_gather.sv
// Width upsizer: packs RATIO beats of IN_W bits LSB-lane-first into one word,
// padding lanes left empty by in_last. Optional BUS_GATHER_PARITY_EN adds out_parity.
module bus_gather
   import bus_gather_pkg::*;
#(
   parameter int   IN_W    = DEF_IN_W,
   parameter int   RATIO   = DEF_RATIO,
   parameter logic PAD_BIT = DEF_PAD_BIT,
   localparam int  CNT_W   = count_width(RATIO)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IN_W*RATIO-1:0] out_data,
   output logic [CNT_W-1:0]      out_count
`ifdef BUS_GATHER_PARITY_EN
   ,
   output logic [RATIO-1:0]      out_parity
`endif
);

   logic [CNT_W-1:0]      cnt;
   logic [IN_W*RATIO-1:0] acc;
   logic [IN_W*RATIO-1:0] next_word;
   logic                  accept;
   logic                  close;
   logic                  fill;

   // in_ready depends only on registered state and out_ready.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign close    = accept && (in_last || (cnt == CNT_W'(RATIO - 1)));
   assign fill     = accept && !close;

   // Per-lane accumulator and the word that a closing beat would emit.
   for (genvar k = 0; k < RATIO; k++) begin : g_lane
      logic [IN_W-1:0] lane_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            lane_q <= '0;
         end else if (fill && (cnt == CNT_W'(k))) begin
            lane_q <= in_data;
         end
      end

      assign acc[k*IN_W +: IN_W] = lane_q;
      assign next_word[k*IN_W +: IN_W] =
         (CNT_W'(k) < cnt)  ? acc[k*IN_W +: IN_W] :
         (CNT_W'(k) == cnt) ? in_data :
                              {IN_W{PAD_BIT}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (close) begin
         // A close during a drain replaces the held word without a bubble.
         cnt       <= '0;
         out_valid <= 1'b1;
         out_data  <= next_word;
         out_count <= cnt + CNT_W'(1);
      end else begin
         if (fill) cnt <= cnt + CNT_W'(1);
         if (out_ready) out_valid <= 1'b0;
      end
   end

`ifdef BUS_GATHER_PARITY_EN
   logic [RATIO-1:0] next_parity;

   for (genvar k = 0; k < RATIO; k++) begin : g_par
      assign next_parity[k] = lane_parity(LANE_MAX_W'(next_word[k*IN_W +: IN_W]), IN_W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity <= '0;
      end else if (close) begin
         out_parity <= next_parity;
      end
   end
`endif

endmodule

// File: tb/tb_bus_gather.sv
// Self-checking bench for bus_gather (IN_W=8, RATIO=4) with PAD_BIT=0 and PAD_BIT=1 instances.
// Checks out_parity as well when BUS_GATHER_PARITY_EN is defined.
module tb_bus_gather;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [31:0] out_data0, out_data1;
   logic [2:0]  out_count0, out_count1;
`ifdef BUS_GATHER_PARITY_EN
   logic [3:0]  out_parity0, out_parity1;
`endif

   int n_chk;
   int n_err;

   // Reference model: beats gathered so far plus the word currently offered.
   logic [7:0]  lanes[$];
   logic        m_valid;
   logic [31:0] m_word0, m_word1;
   logic [2:0]  m_count;
   logic [3:0]  m_par0, m_par1;

   bus_gather #(.IN_W(8), .RATIO(4), .PAD_BIT(1'b0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_data  (out_data0),
      .out_count (out_count0)
`ifdef BUS_GATHER_PARITY_EN
      ,
      .out_parity(out_parity0)
`endif
   );

   bus_gather #(.IN_W(8), .RATIO(4), .PAD_BIT(1'b1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_data  (out_data1),
      .out_count (out_count1)
`ifdef BUS_GATHER_PARITY_EN
      ,
      .out_parity(out_parity1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      lanes.delete();
      m_valid = 1'b0;
      m_word0 = '0;
      m_word1 = '0;
      m_count = '0;
      m_par0  = '0;
      m_par1  = '0;
   endtask

   task automatic model_emit();
      m_word0 = 32'h0000_0000;
      m_word1 = 32'hFFFF_FFFF;
      foreach (lanes[i]) begin
         m_word0[i*8 +: 8] = lanes[i];
         m_word1[i*8 +: 8] = lanes[i];
      end
      m_count = 3'(lanes.size());
      for (int k = 0; k < 4; k++) begin
         m_par0[k] = ^m_word0[k*8 +: 8];
         m_par1[k] = ^m_word1[k*8 +: 8];
      end
      m_valid = 1'b1;
      lanes.delete();
   endtask

   // One clock: drive at negedge, check in_ready, update model at posedge, check outputs at next negedge.
   task automatic step(input logic v, input logic [7:0] d, input logic l,
                       input logic ordy, input logic r);
      logic exp_ready;
      logic closed;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      rst       = r;
      #1;
      exp_ready = !m_valid || ordy;
      if (!r) begin
         chk("in_ready0", 64'(in_ready0), 64'(exp_ready));
         chk("in_ready1", 64'(in_ready1), 64'(exp_ready));
      end
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         closed = 1'b0;
         if (v && exp_ready) begin
            lanes.push_back(d);
            if (l || lanes.size() == 4) begin
               model_emit();
               closed = 1'b1;
            end
         end
         if (!closed && ordy) m_valid = 1'b0;
      end
      @(negedge clk);
      chk("out_valid0", 64'(out_valid0), 64'(m_valid));
      chk("out_valid1", 64'(out_valid1), 64'(m_valid));
      if (m_valid || r) begin
         chk("out_data0",  64'(out_data0),  64'(m_word0));
         chk("out_count0", 64'(out_count0), 64'(m_count));
         chk("out_data1",  64'(out_data1),  64'(r ? 32'h0 : m_word1));
         chk("out_count1", 64'(out_count1), 64'(m_count));
`ifdef BUS_GATHER_PARITY_EN
         chk("out_parity0", 64'(out_parity0), 64'(m_par0));
         chk("out_parity1", 64'(out_parity1), 64'(r ? 4'h0 : m_par1));
`endif
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      model_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      @(negedge clk);
      step(0, 8'h00, 0, 1, 1);
      step(0, 8'h00, 0, 1, 1);
      chk("reset_data_const", 64'(out_data0), 64'h0);

      // Full word, then idle: out_valid lasts one cycle.
      step(1, 8'h11, 0, 1, 0);
      step(1, 8'h22, 0, 1, 0);
      step(1, 8'h33, 0, 1, 0);
      step(1, 8'h44, 1, 1, 0);
      chk("full_word", 64'(out_data0), 64'h4433_2211);
      step(0, 8'h00, 0, 1, 0);

      // Partial word padded with 0 and with 1.
      step(1, 8'hAA, 0, 1, 0);
      step(1, 8'hBB, 1, 1, 0);
      chk("partial_pad0", 64'(out_data0), 64'h0000_BBAA);
      chk("partial_pad1", 64'(out_data1), 64'hFFFF_BBAA);
      step(0, 8'h00, 0, 1, 0);

      // Back-pressure hold, then drain and close in the same cycle.
      step(1, 8'h11, 0, 1, 0);
      step(1, 8'h22, 0, 1, 0);
      step(1, 8'h33, 0, 1, 0);
      step(1, 8'h44, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 8'hE0 + 8'(i), 0, 0, 0);
      chk("hold_data", 64'(out_data0), 64'h4433_2211);
      step(1, 8'h99, 1, 1, 0);
      chk("replace_word", 64'(out_data0), 64'h0000_0099);
      step(0, 8'h00, 0, 1, 0);

      // Back-to-back beats 0x01..0x0C.
      for (int i = 1; i <= 12; i++) step(1, 8'(i), 0, 1, 0);
      step(0, 8'h00, 0, 1, 0);

      // Reset mid-fill leaves no residue.
      step(1, 8'h11, 0, 1, 0);
      step(1, 8'h22, 0, 1, 0);
      step(0, 8'h00, 0, 1, 1);
      step(1, 8'h55, 1, 1, 0);
      chk("post_reset_word", 64'(out_data0), 64'h0000_0055);

      // Parity example word 0x01030700.
      step(1, 8'h00, 0, 1, 0);
      step(1, 8'h07, 0, 1, 0);
      step(1, 8'h03, 0, 1, 0);
      step(1, 8'h01, 0, 1, 0);
`ifdef BUS_GATHER_PARITY_EN
      chk("parity_example", 64'(out_parity0), 64'b1010);
`endif
      step(0, 8'h00, 0, 1, 0);

      // Randomized traffic with back-pressure, early last and occasional reset.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
